// File: rtl/ex_div_sequencer.sv
// ---------------------------------------------------------------------------
// ex_div_sequencer
//
// Multi-cycle RV32M divide/remainder unit that sits beside the ALU in the
// execute stage. It runs a radix-2 restoring division and produces one
// quotient bit per clock. While an operation is in flight it holds the front
// of the pipeline with stall_out. The destination register tag travels with
// the result so the EX/MEM handoff can write it back.
//
// Parameters
//   XLEN   operand/result width
//   CNT_W  iteration counter width (2^CNT_W > XLEN)
//
// Ports
//   clk           clock
//   rst           synchronous, active-high reset
//   valid_in      divide instruction present in EX this cycle
//   div_op        00=DIV, 01=DIVU, 10=REM, 11=REMU
//   rs1_data      dividend
//   rs2_data      divisor
//   rd_in         destination register
//   flush         kill the in-flight operation (branch/jump redirect)
//   stall_out     freeze PC, IF/ID and ID/EX this cycle (combinational)
//   result_valid  one-cycle pulse; result and rd_out valid
//   result        quotient or remainder (registered, holds after DONE)
//   rd_out        destination register of result (registered)
// ---------------------------------------------------------------------------
module ex_div_sequencer #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_in,
    input  logic [1:0]      div_op,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [4:0]      rd_in,
    input  logic            flush,
    output logic            stall_out,
    output logic            result_valid,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_DONE = 2'b10
    } state_t;

    localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};

    // XLEN-bit two's complement negation; INT_MIN maps onto itself.
    function automatic logic [XLEN-1:0] neg2c(input logic [XLEN-1:0] v);
        return ~v + XLEN'(1);
    endfunction

    // Magnitude of a signed operand, returned as an unsigned value so that
    // |INT_MIN| = 2^(XLEN-1) is represented exactly.
    function automatic logic [XLEN-1:0] abs_val(input logic signed [XLEN-1:0] v);
        return v[XLEN-1] ? neg2c(v) : v;
    endfunction

    // Sign fix-up applied when the final result is loaded. Quotient is
    // negated only for DIV when operand signs differ; remainder only for
    // REM when the dividend is negative.
    function automatic logic [XLEN-1:0] sign_fix(
        input logic [1:0]      op,
        input logic [XLEN-1:0] q,
        input logic [XLEN-1:0] r,
        input logic            q_neg,
        input logic            r_neg
    );
        logic [XLEN-1:0] res;
        if (op[1]) begin
            res = (r_neg && !op[0]) ? neg2c(r) : r;
        end else begin
            res = (q_neg && !op[0]) ? neg2c(q) : q;
        end
        return res;
    endfunction

    state_t            state_q,        state_d;
    logic [1:0]        op_q,           op_d;
    logic [4:0]        rd_q,           rd_d;
    logic [XLEN-1:0]   quot_q,         quot_d;
    logic [XLEN-1:0]   dvs_q,          dvs_d;
    logic [XLEN:0]     rem_q,          rem_d;
    logic [CNT_W-1:0]  cnt_q,          cnt_d;
    logic              q_neg_q,        q_neg_d;
    logic              r_neg_q,        r_neg_d;
    logic [XLEN-1:0]   result_q,       result_d;
    logic [4:0]        rd_out_q,       rd_out_d;
    logic              result_valid_q, result_valid_d;

    // Operand decode for the accept cycle.
    logic signed [XLEN-1:0] rs1_s;
    logic signed [XLEN-1:0] rs2_s;
    logic                   op_signed;
    logic                   div_by_zero;
    logic                   sgn_overflow;
    logic [XLEN-1:0]        special_res;

    // One restoring-division step.
    logic [XLEN:0]          rem_sh;
    logic signed [XLEN+1:0] trial;
    logic                   trial_ok;
    logic [XLEN:0]          rem_nx;
    logic [XLEN-1:0]        quot_nx;

    always_comb begin
        rs1_s        = $signed(rs1_data);
        rs2_s        = $signed(rs2_data);
        op_signed    = ~div_op[0];
        div_by_zero  = (rs2_data == '0);
        sgn_overflow = op_signed && (rs1_data == INT_MIN) && (rs2_data == ALL_ONES);

        if (div_by_zero) begin
            special_res = div_op[1] ? rs1_data : ALL_ONES;
        end else begin
            special_res = div_op[1] ? '0 : INT_MIN;
        end
    end

    always_comb begin
        rem_sh  = {rem_q[XLEN-1:0], quot_q[XLEN-1]};
        trial   = $signed({1'b0, rem_sh}) - $signed({2'b00, dvs_q});
        // A set top bit of the partial remainder means the shifted value
        // certainly exceeds the divisor, whatever the trial sign says.
        trial_ok = ~trial[XLEN+1] | rem_q[XLEN];
        rem_nx   = trial_ok ? trial[XLEN:0] : rem_sh;
        quot_nx  = {quot_q[XLEN-2:0], trial_ok};
    end

    always_comb begin
        state_d        = state_q;
        op_d           = op_q;
        rd_d           = rd_q;
        quot_d         = quot_q;
        dvs_d          = dvs_q;
        rem_d          = rem_q;
        cnt_d          = cnt_q;
        q_neg_d        = q_neg_q;
        r_neg_d        = r_neg_q;
        result_d       = result_q;
        rd_out_d       = rd_out_q;
        result_valid_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (valid_in) begin
                    op_d    = div_op;
                    rd_d    = rd_in;
                    quot_d  = op_signed ? abs_val(rs1_s) : rs1_data;
                    dvs_d   = op_signed ? abs_val(rs2_s) : rs2_data;
                    rem_d   = '0;
                    cnt_d   = CNT_W'(XLEN);
                    q_neg_d = rs1_data[XLEN-1] ^ rs2_data[XLEN-1];
                    r_neg_d = rs1_data[XLEN-1];
                    if (div_by_zero || sgn_overflow) begin
                        // Result is known now; skip the iteration entirely.
                        state_d        = S_DONE;
                        result_d       = special_res;
                        rd_out_d       = rd_in;
                        result_valid_d = 1'b1;
                    end else begin
                        state_d = S_CALC;
                    end
                end
            end

            S_CALC: begin
                rem_d  = rem_nx;
                quot_d = quot_nx;
                cnt_d  = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d        = S_DONE;
                    result_d       = sign_fix(op_q, quot_nx, rem_nx[XLEN-1:0],
                                              q_neg_q, r_neg_q);
                    rd_out_d       = rd_q;
                    result_valid_d = 1'b1;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A redirect kills anything not yet presented; the output registers
        // keep their previous contents.
        if (flush) begin
            state_d        = S_IDLE;
            result_d       = result_q;
            rd_out_d       = rd_out_q;
            result_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            op_q           <= '0;
            rd_q           <= '0;
            quot_q         <= '0;
            dvs_q          <= '0;
            rem_q          <= '0;
            cnt_q          <= '0;
            q_neg_q        <= 1'b0;
            r_neg_q        <= 1'b0;
            result_q       <= '0;
            rd_out_q       <= '0;
            result_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            op_q           <= op_d;
            rd_q           <= rd_d;
            quot_q         <= quot_d;
            dvs_q          <= dvs_d;
            rem_q          <= rem_d;
            cnt_q          <= cnt_d;
            q_neg_q        <= q_neg_d;
            r_neg_q        <= r_neg_d;
            result_q       <= result_d;
            rd_out_q       <= rd_out_d;
            result_valid_q <= result_valid_d;
        end
    end

    // Stall covers the accept cycle and every iteration, but drops at once
    // on a flush so the redirect can proceed in the same cycle.
    assign stall_out = ~rst & ~flush &
                       (((state_q == S_IDLE) & valid_in) | (state_q == S_CALC));

    assign result_valid = result_valid_q;
    assign result       = result_q;
    assign rd_out       = rd_out_q;

endmodule

// File: tb/tb_ex_div_sequencer.sv
module tb_ex_div_sequencer;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;
    localparam int LAT_N = 33;
    localparam int LAT_S = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in;
    logic [1:0]  div_op;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [4:0]  rd_in;
    logic        flush;
    logic        stall_out;
    logic        result_valid;
    logic [31:0] result;
    logic [4:0]  rd_out;

    ex_div_sequencer #(.XLEN(32), .CNT_W(6)) dut (
        .clk          (clk),
        .rst          (rst),
        .valid_in     (valid_in),
        .div_op       (div_op),
        .rs1_data     (rs1_data),
        .rs2_data     (rs2_data),
        .rd_in        (rd_in),
        .flush        (flush),
        .stall_out    (stall_out),
        .result_valid (result_valid),
        .result       (result),
        .rd_out       (rd_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        int          due;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, req, cyc);
    endtask

    // Monitor: every result_valid pulse must match the oldest expectation.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst === 1'b0 && result_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_result_valid", {31'b0, result_valid}, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("result", result, e.res);
                chk("rd_out", {27'b0, rd_out}, {27'b0, e.rd});
                chk("latency_cycle", cyc, e.due);
            end
        end
    end

    // Issue one op and walk its whole lifetime checking stall_out.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic [31:0] exp_res, input int lat);
        exp_t e;
        @(negedge clk);
        valid_in = 1'b1;
        div_op   = op;
        rs1_data = a;
        rs2_data = b;
        rd_in    = rd;
        e.res = exp_res;
        e.rd  = rd;
        e.due = cyc + lat;
        sb.push_back(e);
        #1 chk("stall_accept", {31'b0, stall_out}, 32'd1);
        @(posedge clk);
        #1 valid_in = 1'b0;
        rs1_data = 32'hDEAD_BEEF;
        rs2_data = 32'h0BAD_F00D;
        rd_in    = 5'd31;
        for (int i = 1; i <= lat; i++) begin
            @(negedge clk);
            #1 chk($sformatf("stall_T+%0d", i), {31'b0, stall_out}, (i < lat) ? 32'd1 : 32'd0);
        end
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin : stim
        rst      = 1'b1;
        valid_in = 1'b1;
        flush    = 1'b0;
        div_op   = OP_DIVU;
        rs1_data = 32'd100;
        rs2_data = 32'd7;
        rd_in    = 5'd3;

        // Reset state, with a request present that must not stall.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_stall", {31'b0, stall_out}, 32'd0);
        chk("rst_result_valid", {31'b0, result_valid}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_rd_out", {27'b0, rd_out}, 32'd0);
        valid_in = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;

        // Normal and special-case operations, issued back to back.
        run_op(OP_DIVU, 32'd100,      32'd7,        5'd5,  32'd14,       LAT_N);
        run_op(OP_REM,  32'hFFFFFFF9, 32'd2,        5'd6,  32'hFFFFFFFF, LAT_N);
        run_op(OP_DIV,  32'hFFFFFFF9, 32'd2,        5'd7,  32'hFFFFFFFD, LAT_N);
        run_op(OP_DIV,  32'd123,      32'd0,        5'd8,  32'hFFFFFFFF, LAT_S);
        run_op(OP_REMU, 32'd123,      32'd0,        5'd9,  32'd123,      LAT_S);
        run_op(OP_DIV,  32'h80000000, 32'hFFFFFFFF, 5'd10, 32'h80000000, LAT_S);
        run_op(OP_REM,  32'h80000000, 32'hFFFFFFFF, 5'd11, 32'd0,        LAT_S);
        run_op(OP_DIVU, 32'h80000000, 32'hFFFFFFFF, 5'd12, 32'd0,        LAT_N);
        run_op(OP_DIV,  32'd100,      32'hFFFFFFF9, 5'd13, 32'hFFFFFFF2, LAT_N);
        run_op(OP_REM,  32'd100,      32'hFFFFFFF9, 5'd14, 32'd2,        LAT_N);
        run_op(OP_REMU, 32'hFFFFFFFF, 32'h10,       5'd15, 32'hF,        LAT_N);
        run_op(OP_REM,  32'hFFFFFF9C, 32'd7,        5'd16, 32'hFFFFFFFE, LAT_N);
        run_op(OP_DIV,  32'hFFFFFFFF, 32'd0,        5'd17, 32'hFFFFFFFF, LAT_S);
        run_op(OP_REM,  32'hFFFFFFFF, 32'd0,        5'd18, 32'hFFFFFFFF, LAT_S);

        // Flush at T+10: the killed op must never present a result.
        @(negedge clk);
        valid_in = 1'b1;
        div_op   = OP_DIVU;
        rs1_data = 32'd1000;
        rs2_data = 32'd3;
        rd_in    = 5'd22;
        @(posedge clk);
        #1 valid_in = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            #1 chk($sformatf("flush_stall_T+%0d", i), {31'b0, stall_out}, 32'd1);
        end
        @(negedge clk);
        flush = 1'b1;
        #1 chk("flush_stall_drop", {31'b0, stall_out}, 32'd0);
        @(posedge clk);
        #1 flush = 1'b0;
        run_op(OP_DIVU, 32'd9, 32'd3, 5'd19, 32'd3, LAT_N);

        // Reset in the middle of a running op.
        @(negedge clk);
        valid_in = 1'b1;
        div_op   = OP_DIV;
        rs1_data = 32'hFFFFFF9C;
        rs2_data = 32'd7;
        rd_in    = 5'd23;
        @(posedge clk);
        #1 valid_in = 1'b0;
        for (int i = 1; i <= 4; i++) @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1 chk("mid_rst_stall", {31'b0, stall_out}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_result_valid", {31'b0, result_valid}, 32'd0);
        chk("post_rst_result", result, 32'd0);
        chk("post_rst_rd_out", {27'b0, rd_out}, 32'd0);
        chk("post_rst_stall", {31'b0, stall_out}, 32'd0);

        run_op(OP_DIVU, 32'd50, 32'd5, 5'd20, 32'd10, LAT_N);
        run_op(OP_REMU, 32'd50, 32'd7, 5'd21, 32'd1,  LAT_N);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/ex_div_sequencer.md
Name: ex_div_sequencer

Overview:
Multi-cycle RV32M divide/remainder unit with its own sequencing FSM, placed beside the ALU in the execute stage. Accepts DIV/DIVU/REM/REMU operands from ID/EX and runs a radix-2 restoring division, one quotient bit per cycle. Holds the pipeline with a stall request until the result is ready. Returns the destination register tag with the result for the EX/MEM handoff.

Parameters:
XLEN, 32, operand/result width
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > XLEN

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
valid_in  in  1  divide instruction present in EX this cycle
div_op  in  2  00=DIV, 01=DIVU, 10=REM, 11=REMU
rs1_data  in  XLEN  dividend
rs2_data  in  XLEN  divisor
rd_in  in  5  destination register
flush  in  1  kill the in-flight operation (branch/jump redirect)
stall_out  out  1  freeze PC, IF/ID and ID/EX this cycle
result_valid  out  1  result and rd_out valid; one-cycle pulse
result  out  XLEN  quotient or remainder
rd_out  out  5  destination register of result

Behaviour:
- Clock and reset: one clock, clk; rst is synchronous and active-high. In any state, rst → IDLE; result_valid=0, result=0, rd_out=0, counter=0, all internal registers=0. stall_out=0 during and after reset.
- States:
  - IDLE: wait for an operation.
  - CALC: iterate.
  - DONE: present the result.
- IDLE, with valid_in=1 and flush=0 (accept cycle T):
  - Latch div_op and rd_in.
  - Latch |rs1| and |rs2|. Absolute value applies only for signed ops (DIV/REM); unsigned ops use raw values.
  - Latch the quotient-sign and remainder-sign flags.
  - Clear the partial remainder (XLEN+1 bits). Load counter=XLEN.
- Special cases decided in the accept cycle; FSM goes IDLE→DONE directly:
  - Divisor==0: quotient=all ones; remainder=rs1_data unmodified.
  - Signed overflow (DIV/REM, rs1=0x80000000, rs2=0xFFFFFFFF): quotient=0x80000000; remainder=0.
- Normal operations: IDLE→CALC. Each CALC cycle:
  - Shift {rem, quot} left by 1.
  - Trial-subtract the divisor. If the result is non-negative, keep it and set quot[0]=1.
  - Decrement the counter.
  - CALC→DONE when the counter reaches 1, i.e. after exactly XLEN CALC cycles.
- Sign fix-up is applied on the DONE-cycle register load:
  - Quotient is negated if the operand signs differ (DIV only).
  - Remainder is negated if the dividend is negative (REM only).
- DONE:
  - result_valid=1 for exactly one cycle; result and rd_out are registered and stable.
  - Next state is IDLE unconditionally. valid_in is ignored in DONE; the pipeline advances at the end of DONE.
- Latency:
  - Normal: accept at T, CALC T+1..T+XLEN, result_valid at T+XLEN+1 (T+33 for XLEN=32).
  - Special case: result_valid at T+1.
- stall_out is combinational: (IDLE & valid_in & ~flush) | CALC. stall_out=0 in DONE.
- result_valid is 0 outside DONE. result and rd_out hold their last value after DONE.
- flush=1, any state: next state IDLE. No result_valid is produced for the flushed op. stall_out=0 in that cycle.
  - Flush in DONE: result_valid is still 1 in that cycle (already committed); next state IDLE.
- Simultaneous rst and flush: rst wins.
- Back-to-back ops: a new op is accepted in the cycle after DONE. There is no overlap.
- No arithmetic wrap-around is visible: negation uses XLEN-bit two's complement, so the overflow case is handled explicitly above.

Test Plan:
- DIVU 100/7: valid_in at T → stall_out=1 T..T+32; result_valid=1 only at T+33, result=14; rd_out=rd_in.
- REM rs1=0xFFFFFFF9 (-7), rs2=2 → result=0xFFFFFFFF (-1) at T+33. DIV with the same operands → 0xFFFFFFFD (-3).
- DIV rs1=123, rs2=0 → result=0xFFFFFFFF at T+1, stall_out=1 only at T. REMU with the same operands → 123.
- DIV 0x80000000/0xFFFFFFFF → 0x80000000 at T+1. REM with the same operands → 0 at T+1.
- Accept at T; flush=1 at T+10 → result_valid never pulses, stall_out=0 from T+10. New DIVU 9/3 accepted at T+11 → result=3 at T+44.
- rst=1 at T+5 of a running op → all outputs 0 at T+6 and FSM in IDLE. An op issued after reset completes normally; back-to-back ops are accepted the cycle after DONE.
